// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits, combinational
// write-to-read bypass, and a sequential sweep that clears the whole bank.
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 REGWRITE,
  input  logic [AW-1:0]        ADR_WR_REG,
  input  logic [WIDTH-1:0]     WR_DATA,
  input  logic                 ISSUE,
  input  logic [AW-1:0]        ADR_ISSUE,
  input  logic [NRD*AW-1:0]    ADR_RD,
  output logic [NRD*WIDTH-1:0] RD_DATA,
  output logic [NRD-1:0]       RD_PENDING,
  input  logic                 CLR_REQ,
  output logic                 CLR_BUSY,
  output logic                 CLR_DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  clr_state_t       state, state_next;
  logic [AW-1:0]    sweep_idx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;

  logic sweeping;
  logic wr_en;
  logic iss_en;

  assign sweeping = (state == SWEEP);
  // Register 0 is hardwired: writes and issues to it never qualify.
  assign wr_en    = REGWRITE && (ADR_WR_REG != '0) && !sweeping;
  assign iss_en   = ISSUE    && (ADR_ISSUE  != '0) && !sweeping;

  // State register and sweep index.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state     <= IDLE;
      sweep_idx <= AW'(1);
    end else begin
      state     <= state_next;
      sweep_idx <= sweeping ? sweep_idx + AW'(1) : AW'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (CLR_REQ) state_next = SWEEP;
      SWEEP:   if (sweep_idx == AW'(DEPTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    CLR_BUSY = 1'b0;
    CLR_DONE = 1'b0;
    case (state)
      SWEEP:   CLR_BUSY = 1'b1;
      DONE:    CLR_DONE = 1'b1;
      default: ;
    endcase
  end

  // Register bank and pending bits.
  always_ff @(posedge clk) begin
    // NOTE: the bank is reset explicitly because reset must leave every
    // register reading zero; this forces flops rather than a RAM macro.
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      pend <= '0;
    end else if (sweeping) begin
      mem[sweep_idx]  <= '0;
      pend[sweep_idx] <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[ADR_WR_REG]  <= WR_DATA;
        pend[ADR_WR_REG] <= 1'b0;
      end
      // Set after the clear so a same-address issue wins over the write.
      if (iss_en) pend[ADR_ISSUE] <= 1'b1;
    end
  end

  // Combinational read ports with bypass from the in-flight write.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          wr_hit;
    logic          iss_hit;

    assign addr    = ADR_RD[i*AW +: AW];
    assign wr_hit  = wr_en  && (ADR_WR_REG == addr);
    assign iss_hit = iss_en && (ADR_ISSUE  == addr);

    assign RD_DATA[i*WIDTH +: WIDTH] = (addr == '0) ? '0 :
                                       wr_hit       ? WR_DATA : mem[addr];
    assign RD_PENDING[i] = (addr != '0) && pend[addr] && !(wr_hit && !iss_hit);
  end

endmodule
